// File: rtl/alu_yoosys.sv
// Registered 16-bit, 8-operation ALU with negative/zero flags and one cycle of latency.
// Optional signed-overflow flag output enabled by defining ALU_OVF_EN.
module alu_yoosys #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_m,
   input  logic [WIDTH-1:0] in_n,
   input  logic             in_c,
   input  logic [2:0]       opc,
   output logic [WIDTH-1:0] out_f,
   output logic             neg,
   output logic             zer,
   output logic             out_valid
`ifdef ALU_OVF_EN
   ,output logic            ovf
`endif
);

   logic [WIDTH-1:0] res_s;
   logic             neg_s;
   logic             zer_s;

   // Combinational result for the selected operation, truncated to WIDTH bits.
   always_comb begin
      res_s = {WIDTH{1'b0}};
      case (opc)
         3'd0: res_s = in_m + in_n + {{(WIDTH-1){1'b0}}, in_c};
         3'd1: res_s = in_m + {1'b0, in_n[WIDTH-1:1]};
         3'd2: begin
            if ($signed(in_m) > $signed(in_n)) begin
               res_s = in_m;
            end else begin
               res_s = in_n;
            end
         end
         3'd3: res_s = {in_m[WIDTH-2:0], 1'b0} + in_m;
         3'd4: res_s = in_m & in_n;
         3'd5: res_s = in_m | in_n;
         3'd6: res_s = ~in_m;
         3'd7: res_s = {WIDTH{1'b0}};
         default: res_s = {WIDTH{1'b0}};
      endcase
      neg_s = res_s[WIDTH-1];
      zer_s = (res_s == {WIDTH{1'b0}});
   end

`ifdef ALU_OVF_EN
   logic [WIDTH+1:0] wide_m_s;
   logic [WIDTH+1:0] wide_s;
   logic             ovf_s;

   // Exact signed result two bits wider than WIDTH; overflow when the top three bits disagree.
   always_comb begin
      wide_m_s = {{2{in_m[WIDTH-1]}}, in_m};
      wide_s   = {(WIDTH+2){1'b0}};
      ovf_s    = 1'b0;
      case (opc)
         3'd0: wide_s = wide_m_s + {{2{in_n[WIDTH-1]}}, in_n} + {{(WIDTH+1){1'b0}}, in_c};
         3'd1: wide_s = wide_m_s + {3'b000, in_n[WIDTH-1:1]};
         3'd3: wide_s = {wide_m_s[WIDTH:0], 1'b0} + wide_m_s;
         default: wide_s = {(WIDTH+2){1'b0}};
      endcase
      if ((opc == 3'd0) || (opc == 3'd1) || (opc == 3'd3)) begin
         ovf_s = !((wide_s[WIDTH+1] == wide_s[WIDTH]) && (wide_s[WIDTH] == wide_s[WIDTH-1]));
      end else begin
         ovf_s = 1'b0;
      end
   end

   // Overflow flag is loaded together with the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (in_valid) begin
         ovf <= ovf_s;
      end
   end
`endif

   // Output stage: load on accepted operation, otherwise hold the result and drop valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_f     <= {WIDTH{1'b0}};
         neg       <= 1'b0;
         zer       <= 1'b0;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         out_f     <= res_s;
         neg       <= neg_s;
         zer       <= zer_s;
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_yoosys.sv
// Scoreboard bench for alu_yoosys: directed test-plan vectors plus random traffic
// checked against an integer-arithmetic reference model. Define ALU_OVF_EN to also check ovf.
module tb_alu_yoosys;

   typedef struct {
      logic [15:0] f;
      logic        n;
      logic        z;
      logic        o;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_m = 16'h0000;
   logic [15:0] in_n = 16'h0000;
   logic        in_c = 1'b0;
   logic [2:0]  opc = 3'd0;
   logic [15:0] out_f;
   logic        neg;
   logic        zer;
   logic        out_valid;
`ifdef ALU_OVF_EN
   logic        ovf;
`endif

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_chk = 0;
   int          n_err = 0;
   int          valid_cnt = 0;
   logic [15:0] last_f = 16'h0000;
   logic        last_n = 1'b0;
   logic        last_z = 1'b0;
   logic        last_o = 1'b0;

   alu_yoosys #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_m      (in_m),
      .in_n      (in_n),
      .in_c      (in_c),
      .opc       (opc),
      .out_f     (out_f),
      .neg       (neg),
      .zer       (zer),
      .out_valid (out_valid)
`ifdef ALU_OVF_EN
      ,.ovf      (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Reference: exact integer result, then wrap to 16 bits.
   function automatic exp_t model(logic [15:0] m, logic [15:0] n, logic c, logic [2:0] op);
      exp_t e;
      int   sm;
      int   sn;
      int   r;
      logic [31:0] rv;
      sm = $signed(m);
      sn = $signed(n);
      e.o = 1'b0;
      case (op)
         3'd0: r = sm + sn + int'(c);
         3'd1: r = sm + int'(n >> 1);
         3'd2: r = (sm > sn) ? sm : sn;
         3'd3: r = 3 * sm;
         3'd4: r = int'(m & n);
         3'd5: r = int'(m | n);
         3'd6: r = int'(~m);
         default: r = 0;
      endcase
      if (op == 3'd0 || op == 3'd1 || op == 3'd3) e.o = (r > 32767) || (r < -32768);
      rv  = r;
      e.f = rv[15:0];
      e.n = e.f[15];
      e.z = (e.f == 16'h0000);
      return e;
   endfunction

   task automatic check(string name, logic [15:0] act, logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic issue(logic [15:0] m, logic [15:0] n, logic c, logic [2:0] op);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_m = m;
      in_n = n;
      in_c = c;
      opc = op;
      sb.push_back(model(m, n, c, op));
      n_vec++;
   endtask

   task automatic idle(int k);
      for (int i = 0; i < k; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_m = 16'($urandom);
         in_n = 16'($urandom);
         opc = 3'($urandom);
      end
   endtask

   // Monitor: pop and compare on every valid output, check hold when idle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            last_f = 16'h0000;
            last_n = 1'b0;
            last_z = 1'b0;
            last_o = 1'b0;
         end else if (out_valid === 1'b1) begin
            valid_cnt++;
            if (sb.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL spurious_valid: got out_valid=1 expected 0 at %0t", $time);
            end else begin
               e = sb.pop_front();
               check("result", out_f, e.f);
               check("neg", {15'd0, neg}, {15'd0, e.n});
               check("zer", {15'd0, zer}, {15'd0, e.z});
`ifdef ALU_OVF_EN
               check("ovf", {15'd0, ovf}, {15'd0, e.o});
`endif
               last_f = e.f;
               last_n = e.n;
               last_z = e.z;
               last_o = e.o;
            end
         end else begin
            check("out_valid_idle", {15'd0, out_valid}, 16'h0000);
            check("hold_f", out_f, last_f);
            check("hold_flags", {14'd0, neg, zer}, {14'd0, last_n, last_z});
`ifdef ALU_OVF_EN
            check("hold_ovf", {15'd0, ovf}, {15'd0, last_o});
`endif
         end
      end
   end

   initial begin
      int cnt0;
      #1;
      check("reset_out_valid", {15'd0, out_valid}, 16'h0000);
      check("reset_f", out_f, 16'h0000);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // Directed test-plan vectors
      issue(16'h7FFF, 16'h0001, 1'b0, 3'd0);
      issue(16'hFFFF, 16'h0000, 1'b1, 3'd0);
      issue(16'h0001, 16'hFFFF, 1'b0, 3'd1);
      issue(16'h5556, 16'h1234, 1'b1, 3'd3);
      issue(16'hFFFB, 16'h0003, 1'b0, 3'd2);
      issue(16'h0004, 16'h8000, 1'b0, 3'd2);
      issue(16'h0007, 16'h0007, 1'b0, 3'd2);
      issue(16'hF0F0, 16'h0FF0, 1'b0, 3'd4);
      issue(16'hF0F0, 16'h0FF0, 1'b0, 3'd5);
      issue(16'hF0F0, 16'h0FF0, 1'b0, 3'd6);
      issue(16'hFFFF, 16'h0FF0, 1'b1, 3'd6);
      issue(16'h1234, 16'h5678, 1'b1, 3'd7);
      issue(16'h8000, 16'hFFFF, 1'b0, 3'd0);
      issue(16'hAAAA, 16'h0000, 1'b0, 3'd3);
      idle(3);

      // Handshake: three back-to-back, then idle; hold checked by monitor
      cnt0 = valid_cnt;
      issue(16'h0011, 16'h0022, 1'b1, 3'd0);
      issue(16'h0100, 16'h0200, 1'b0, 3'd5);
      issue(16'h8001, 16'h0000, 1'b0, 3'd1);
      idle(4);
      check("handshake_valid_cycles", 16'(valid_cnt - cnt0), 16'd3);

      // Random traffic with random gaps
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3, 0) != 0) begin
            issue(16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom));
         end else begin
            idle(1);
         end
      end
      issue(16'h4321, 16'h1111, 1'b0, 3'd4);

      // Asynchronous reset mid-stream with in_valid high
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_m = 16'h1234;
      in_n = 16'h0001;
      opc = 3'd0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_f", out_f, 16'h0000);
      check("async_rst_flags", {14'd0, neg, zer}, 16'h0000);
      check("async_rst_valid", {15'd0, out_valid}, 16'h0000);
`ifdef ALU_OVF_EN
      check("async_rst_ovf", {15'd0, ovf}, 16'h0000);
`endif
      sb.delete();
      @(posedge clk);
      #1;
      check("rst_held_valid", {15'd0, out_valid}, 16'h0000);
      in_valid = 1'b0;
      rst_n = 1'b1;
      idle(2);
      issue(16'h7FFF, 16'h0001, 1'b0, 3'd0);
      issue(16'h0000, 16'h0000, 1'b0, 3'd4);
      idle(3);

      n_chk++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_yoosys.md
Name: alu_yoosys

Overview:
16-bit, 8-operation registered ALU with negative and zero status flags. Operands are sampled with a valid strobe. Result and flags appear registered one clock later. Used as a small datapath arithmetic unit; behaviour is identical to the combinational reference ALU, plus one pipeline register stage.

Parameters:
WIDTH, 16, operand/result width; all rules below are written for 16 and scale with WIDTH.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands/opcode valid this cycle
in_m  in  16  operand M, two's complement signed
in_n  in  16  operand N, two's complement signed
in_c  in  1  carry-in (used by op 0 only)
opc  in  3  operation select
out_f  out  16  registered result, signed
neg  out  1  registered negative flag
zer  out  1  registered zero flag
out_valid  out  1  high for one cycle per accepted operation
ovf  out  1  signed overflow flag (present only with ALU_OVF_EN)

Behaviour:
- Reset (rst_n low, asynchronous): out_f=0, neg=0, zer=0, out_valid=0, ovf=0. Registers hold reset while rst_n is low. Release is sampled on the next rising clk.
- Latency is 1 cycle. On a rising clk with in_valid=1, the result of the current inputs is loaded into out_f/neg/zer, and out_valid is set to 1.
- On a rising clk with in_valid=0: out_valid is set to 0 and out_f/neg/zer hold their previous values.
- There is no backpressure. Back-to-back in_valid is accepted every cycle.
- Operations (all results truncated modulo 2^16, no saturation):
  - 0: M + N + C, with C zero-extended.
  - 1: M + (N >> 1). This is a logical right shift: zero fills the MSB.
  - 2: max(M, N), using a signed compare. If M == N, the result is N (same value).
  - 3: 3*M, computed as (M << 1) + M, truncated.
  - 4: M & N.
  - 5: M | N.
  - 6: ~M.
  - 7: 0.
- Flags are computed from the truncated 16-bit result, in the same cycle as out_f:
  - zer = (result == 0).
  - neg = result[15].
- in_c is ignored for ops 1-7.
- A reset asserted mid-operation discards any pending result. out_valid does not assert for the discarded operation.
- Outputs must not contain X or Z for any opcode. No tri-state muxing is used internally.

Optional Feature:
- Macro: ALU_OVF_EN.
- When defined:
  - Output ovf exists and is registered alongside out_f.
  - ovf=1 when the exact signed result of op 0, 1 or 3 is outside [-32768, 32767].
  - For op 1, N>>1 is treated as non-negative (0..32767).
  - ovf=0 for ops 2, 4, 5, 6, 7.
  - ovf resets to 0.
- When not defined: the ovf port and its logic are absent, and all other behaviour is unchanged.

Test Plan:
- Reset: assert rst_n=0 mid-stream with in_valid=1 -> out_f=0x0000, neg=0, zer=0, out_valid=0 immediately, without waiting for clk.
- Op 0: M=0x7FFF, N=0x0001, C=0 -> next cycle out_f=0x8000, neg=1, zer=0 (ovf=1 if ALU_OVF_EN). Then M=0xFFFF, N=0x0000, C=1 -> out_f=0x0000, zer=1.
- Op 1: M=0x0001, N=0xFFFF -> 0x0001 + 0x7FFF = 0x8000, neg=1. Op 3: M=0x5556 -> out_f=0x0002 (truncated), zer=0.
- Op 2: M=0xFFFB (-5), N=0x0003 -> out_f=0x0003, neg=0. Op 2: M=0x0004, N=0x8000 -> out_f=0x0004.
- Ops 4/5/6/7: M=0xF0F0, N=0x0FF0 -> AND=0x00F0, OR=0xFFF0 (neg=1), NOT M=0x0F0F. Op 6 with M=0xFFFF -> 0x0000, zer=1. Op 7 -> 0x0000, zer=1.
- Handshake: 3 back-to-back in_valid cycles, then 2 idle cycles -> out_valid high for exactly 3 cycles, and out_f holds the last result during the idle cycles.
